// File: rtl/fifo_pkg.sv
// Shared helpers for the byte FIFOs: byte width, ceil-log2 and pointer-width sizing.
package fifo_pkg;

  localparam int BYTE = 8;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Index width for a table of `depth` entries, never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mi_lane.sv
// Maps a multi-byte write starting at tail onto storage slots: per-slot write
// enable plus which data_i lane feeds that slot, with wrap past the last slot.
module fifo_mi_lane
  import fifo_pkg::*;
#(
  parameter int INCUT       = 4,
  parameter int FIFO_LENGTH = 64
) (
  input  logic [ptr_w(FIFO_LENGTH)-1:0] tail,
  input  logic [5:0]                    w_count,
  input  logic                          accept,
  output logic [FIFO_LENGTH-1:0]        slot_we,
  output logic [ptr_w(INCUT)-1:0]       slot_sel [FIFO_LENGTH]
);

  localparam int PW = ptr_w(FIFO_LENGTH);
  localparam int AW = PW + 1;
  localparam int LW = ptr_w(INCUT);

  logic [AW-1:0] tail_ext;
  assign tail_ext = {1'b0, tail};

  for (genvar gi = 0; gi < FIFO_LENGTH; gi++) begin : g_slot
    localparam logic [AW-1:0] SLOT      = AW'(gi);
    localparam logic [AW-1:0] SLOT_WRAP = AW'(gi + FIFO_LENGTH);
    logic [AW-1:0] off;

    // Distance of this slot from tail, going forward around the ring.
    assign off           = (SLOT >= tail_ext) ? (SLOT - tail_ext) : (SLOT_WRAP - tail_ext);
    assign slot_we[gi]   = accept && (32'(off) < 32'(w_count));
    assign slot_sel[gi]  = LW'(off);
  end

endmodule

// File: rtl/fifo_mi.sv
// Multi-input byte FIFO: queues 1..INCUT bytes per write (all or nothing),
// drains one byte per read with first-word-fall-through output.
module fifo_mi
  import fifo_pkg::*;
#(
  parameter int INCUT       = 4,
  parameter int FIFO_LENGTH = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [INCUT*8-1:0]                 data_i,
  input  logic                               w_en,
  input  logic [5:0]                         w_count,
  output logic                               w_drop,
  input  logic                               r_en,
  output logic [7:0]                         data_o,
  output logic                               empty,
  output logic                               full,
  output logic [clog2(FIFO_LENGTH+1)-1:0]    level,
  output logic [clog2(FIFO_LENGTH+1)-1:0]    space
);

  localparam int PW  = ptr_w(FIFO_LENGTH);
  localparam int AW  = PW + 1;
  localparam int LVW = clog2(FIFO_LENGTH + 1);
  localparam int LW  = ptr_w(INCUT);

  logic [BYTE-1:0] mem_q [FIFO_LENGTH];
  logic [BYTE-1:0] mem_d [FIFO_LENGTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [LVW-1:0]  level_q, level_d, space_w;
  logic            w_drop_q, w_drop_d;

  logic                 wc_ok, accept, pop;
  logic [AW-1:0]        tail_sum, head_sum;
  logic [FIFO_LENGTH-1:0] slot_we;
  logic [LW-1:0]        slot_sel [FIFO_LENGTH];
  logic [BYTE-1:0]      lane_byte [INCUT];

  for (genvar gi = 0; gi < INCUT; gi++) begin : g_lane
    assign lane_byte[gi] = data_i[gi*BYTE +: BYTE];
  end

  fifo_mi_lane #(
    .INCUT       (INCUT),
    .FIFO_LENGTH (FIFO_LENGTH)
  ) u_lane (
    .tail     (tail_q),
    .w_count  (w_count),
    .accept   (accept),
    .slot_we  (slot_we),
    .slot_sel (slot_sel)
  );

  always_comb begin
    space_w  = LVW'(FIFO_LENGTH) - level_q;
    // Acceptance looks only at pre-edge space; a same-cycle read gives no credit.
    wc_ok    = (w_count != 6'd0) && (int'(w_count) <= INCUT) && (int'(w_count) <= int'(space_w));
    accept   = enable && w_en && wc_ok;
    w_drop_d = enable && w_en && (w_count != 6'd0) && !wc_ok;
    pop      = enable && r_en && (level_q != '0);

    tail_sum = {1'b0, tail_q} + AW'(w_count);
    head_sum = {1'b0, head_q} + AW'(1);

    tail_d = tail_q;
    if (accept) begin
      tail_d = (tail_sum >= AW'(FIFO_LENGTH)) ? PW'(tail_sum - AW'(FIFO_LENGTH)) : PW'(tail_sum);
    end

    head_d = head_q;
    if (pop) begin
      head_d = (head_sum >= AW'(FIFO_LENGTH)) ? PW'(head_sum - AW'(FIFO_LENGTH)) : PW'(head_sum);
    end

    level_d = level_q + (accept ? LVW'(w_count) : '0) - LVW'(pop);
  end

  for (genvar gi = 0; gi < FIFO_LENGTH; gi++) begin : g_mem
    assign mem_d[gi] = slot_we[gi] ? lane_byte[slot_sel[gi]] : mem_q[gi];
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      level_q  <= '0;
      w_drop_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      level_q  <= level_d;
      w_drop_q <= w_drop_d;
    end
  end

  assign level  = level_q;
  assign space  = space_w;
  assign empty  = (level_q == '0);
  assign full   = (level_q == LVW'(FIFO_LENGTH));
  assign w_drop = w_drop_q;
  assign data_o = (level_q != '0) ? mem_q[head_q] : 8'h00;

endmodule

// File: tb/tb_fifo_mi.sv
// Self-checking bench for fifo_mi: directed scenarios then random traffic,
// compared against a byte-queue reference model.
module tb_fifo_mi;

  localparam int INCUT = 4;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset, enable, w_en, r_en;
  logic [31:0] data_i;
  logic [5:0]  w_count;
  logic        w_drop, empty, full;
  logic [7:0]  data_o;
  logic [6:0]  level, space;

  int total = 0;
  int bad   = 0;

  byte unsigned model_q[$];
  bit           model_drop = 1'b0;

  always #5 clk = ~clk;

  fifo_mi #(.INCUT(INCUT), .FIFO_LENGTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .data_i  (data_i),
    .w_en    (w_en),
    .w_count (w_count),
    .w_drop  (w_drop),
    .r_en    (r_en),
    .data_o  (data_o),
    .empty   (empty),
    .full    (full),
    .level   (level),
    .space   (space)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ".level"}, 32'(level), 32'(n));
    chk({tag, ".space"}, 32'(space), 32'(DEPTH - n));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"},  32'(full),  32'(n == DEPTH));
    chk({tag, ".drop"},  32'(w_drop), 32'(model_drop));
    chk({tag, ".data_o"}, 32'(data_o), (n > 0) ? 32'(model_q[0]) : 32'h0);
  endtask

  // One clock: drive inputs, predict from the pre-edge model, sample #1 after the edge.
  task automatic cyc(input string tag, input bit rst, input bit en, input bit we, input int wc,
                     input logic [31:0] d, input bit re);
    bit acc, pop, drop;
    int n;
    reset = rst; enable = en; w_en = we; w_count = 6'(wc); data_i = d; r_en = re;
    n    = model_q.size();
    acc  = en && we && wc >= 1 && wc <= INCUT && wc <= DEPTH - n;
    drop = en && we && wc != 0 && !acc;
    pop  = en && re && n > 0;
    @(posedge clk);
    #1;
    if (rst) begin
      model_q.delete();
      model_drop = 1'b0;
    end else begin
      model_drop = drop;
      if (pop) void'(model_q.pop_front());
      if (acc) for (int i = 0; i < wc; i++) model_q.push_back(d[i*8 +: 8]);
    end
    $display("%s rst=%0b en=%0b we=%0b wc=%0d d=%h re=%0b -> level=%0d drop=%0b data_o=%h",
             tag, rst, en, we, wc, d, re, level, w_drop, data_o);
    check_all(tag);
  endtask

  task automatic do_reset();
    cyc("reset", 1, 1, 0, 0, 32'h0, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; w_en = 1'b0; r_en = 1'b0; w_count = '0; data_i = '0;
    @(posedge clk); #1;

    // 1: basic write of 3 bytes, read back in order
    do_reset();
    cyc("t1.wr", 0, 1, 1, 3, 32'h99CCBBAA, 0);
    chk("t1.head_aa", 32'(data_o), 32'hAA);
    for (int i = 0; i < 3; i++) cyc("t1.rd", 0, 1, 0, 0, 32'h0, 1);
    chk("t1.empty_after", 32'(empty), 32'h1);

    // 2: fill to full, extra write dropped
    do_reset();
    for (int i = 0; i < 16; i++) cyc("t2.fill", 0, 1, 1, 4, $urandom, 0);
    chk("t2.full", 32'(full), 32'h1);
    cyc("t2.over", 0, 1, 1, 1, 32'h5A, 0);
    chk("t2.drop", 32'(w_drop), 32'h1);
    cyc("t2.idle", 0, 1, 0, 0, 32'h0, 0);

    // 3: move head/tail to 62, then a write that wraps past the end
    do_reset();
    for (int i = 0; i < 15; i++) cyc("t3.pre", 0, 1, 1, 4, $urandom, 0);
    cyc("t3.pre", 0, 1, 1, 2, $urandom, 0);
    for (int i = 0; i < 62; i++) cyc("t3.drain", 0, 1, 0, 0, 32'h0, 1);
    cyc("t3.wrap", 0, 1, 1, 4, 32'h44332211, 0);
    for (int i = 0; i < 4; i++) cyc("t3.rd", 0, 1, 0, 0, 32'h0, 1);

    // 4: simultaneous write+read near full; no read credit at full
    do_reset();
    for (int i = 0; i < 15; i++) cyc("t4.fill", 0, 1, 1, 4, $urandom, 0);
    cyc("t4.fill", 0, 1, 1, 3, $urandom, 0);
    cyc("t4.wr_rd63", 0, 1, 1, 1, 32'h77, 1);
    chk("t4.level63", 32'(level), 32'd63);
    cyc("t4.to64", 0, 1, 1, 1, 32'h78, 0);
    cyc("t4.wr_rd64", 0, 1, 1, 1, 32'h79, 1);
    chk("t4.level_after", 32'(level), 32'd63);

    // 5: oversize, zero-count and read-on-empty
    do_reset();
    cyc("t5.wc5", 0, 1, 1, 5, 32'hDEADBEEF, 0);
    cyc("t5.wc0", 0, 1, 1, 0, 32'hDEADBEEF, 0);
    cyc("t5.rd_empty", 0, 1, 0, 0, 32'h0, 1);

    // 6: freeze with requests active, then reset mid-stream
    do_reset();
    for (int i = 0; i < 2; i++) cyc("t6.fill", 0, 1, 1, 4, $urandom, 0);
    cyc("t6.fill", 0, 1, 1, 2, $urandom, 0);
    cyc("t6.drop", 0, 1, 1, 6, 32'h0, 0);
    cyc("t6.frozen", 0, 0, 1, 3, $urandom, 1);
    cyc("t6.frozen", 0, 0, 1, 1, $urandom, 1);
    cyc("t6.midrst", 1, 1, 1, 2, $urandom, 1);
    chk("t6.level0", 32'(level), 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", ($urandom_range(0, 149) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 1) == 1), int'($urandom_range(0, 6)), $urandom,
          ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
